// File: rtl/tis_exec_pkg.sv
// Shared types and constants for the TIS-100 execute stage.
// Word width, port count, saturation bound and the decoded-field enums live here.
package tis_exec_pkg;

    localparam int WORD_W  = 11;
    localparam int NPORTS  = 4;
    localparam int SAT_MAX = 999;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_SWP  = 3'd2,
        OP_SAV  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_NEG  = 3'd6,
        OP_RSVD = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        SRC_IMM   = 3'd0,
        SRC_ACC   = 3'd1,
        SRC_NIL   = 3'd2,
        SRC_UP    = 3'd3,
        SRC_RIGHT = 3'd4,
        SRC_DOWN  = 3'd5,
        SRC_LEFT  = 3'd6,
        SRC_ANY   = 3'd7
    } src_t;

    typedef enum logic [2:0] {
        DST_ACC   = 3'd0,
        DST_NIL1  = 3'd1,
        DST_NIL2  = 3'd2,
        DST_UP    = 3'd3,
        DST_RIGHT = 3'd4,
        DST_DOWN  = 3'd5,
        DST_LEFT  = 3'd6,
        DST_NIL7  = 3'd7
    } dst_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_PUSH   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_NEG  = 2'd3
    } alu_op_t;

    function automatic logic op_reads_src(input opcode_t op);
        return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic dst_is_port(input dst_t d);
        return (d == DST_UP) || (d == DST_RIGHT) || (d == DST_DOWN) || (d == DST_LEFT);
    endfunction

endpackage

// File: rtl/tis_sat_addsub.sv
// Combinational saturating pass/add/sub/neg on signed W-bit words.
// One guard bit holds every intermediate exactly before clamping to +/-SAT.
module tis_sat_addsub
    import tis_exec_pkg::*;
#(
    parameter int W   = WORD_W,
    parameter int SAT = SAT_MAX
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  alu_op_t      i_op,
    output logic [W-1:0] o_y
);

    localparam logic signed [W:0] P_MAX = (W+1)'(SAT);
    localparam logic signed [W:0] P_MIN = -P_MAX;

    logic signed [W:0] w_a;
    logic signed [W:0] w_b;
    logic signed [W:0] w_r;

    assign w_a = {i_a[W-1], i_a};
    assign w_b = {i_b[W-1], i_b};

    always_comb begin
        w_r = w_b;
        case (i_op)
            ALU_PASS: w_r = w_b;
            ALU_ADD:  w_r = w_a + w_b;
            ALU_SUB:  w_r = w_a - w_b;
            ALU_NEG:  w_r = -w_a;
            default:  w_r = w_b;
        endcase
    end

    always_comb begin
        if (w_r > P_MAX) begin
            o_y = P_MAX[W-1:0];
        end else if (w_r < P_MIN) begin
            o_y = P_MIN[W-1:0];
        end else begin
            o_y = w_r[W-1:0];
        end
    end

endmodule

// File: rtl/tis_exec.sv
// TIS-100 execute stage: operand fetch, port push and ACC/BAK strobes.
// TIS_EXEC_ANY_EN enables src=ANY port reads; otherwise ANY decodes as NIL.
//   state  | meaning
//   IDLE   | waiting for an instruction
//   FETCH  | blocking read from a neighbour port
//   PUSH   | blocking write of the operand to a neighbour port
//   COMMIT | one-cycle register-file strobe
module tis_exec
    import tis_exec_pkg::*;
(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_instr_valid,
    output logic                       o_instr_ready,
    input  logic [2:0]                 i_op,
    input  logic [2:0]                 i_src,
    input  logic [2:0]                 i_dst,
    input  logic [WORD_W-1:0]          i_imm,
    input  logic [WORD_W-1:0]          i_acc,
    output logic                       o_rf_write,
    output logic                       o_rf_swap,
    output logic                       o_rf_save,
    output logic [WORD_W-1:0]          o_rf_write_data,
    input  logic [NPORTS-1:0]          i_rd_valid,
    input  logic [NPORTS*WORD_W-1:0]   i_rd_data,
    output logic [NPORTS-1:0]          o_rd_ready,
    output logic [NPORTS-1:0]          o_wr_valid,
    output logic [WORD_W-1:0]          o_wr_data,
    input  logic [NPORTS-1:0]          i_wr_ready,
    output logic                       o_busy
);

    state_t  r_state;
    state_t  w_state_nxt;
    opcode_t r_op;
    src_t    r_src;
    dst_t    r_dst;
    word_t   r_operand;

    opcode_t w_in_op;
    src_t    w_in_src;
    dst_t    w_in_dst;
    logic    w_accept;
    logic    w_in_port_src;
    word_t   w_in_operand;
    logic    w_rd_fire;
    logic [1:0] w_rd_idx;
    logic [1:0] w_wr_idx;
    word_t   w_rd_word;
    alu_op_t w_alu_op;
    logic [WORD_W-1:0] w_alu_y;

    assign w_in_op  = opcode_t'(i_op);
    assign w_in_src = src_t'(i_src);
    assign w_in_dst = dst_t'(i_dst);
    assign w_accept = (r_state == ST_IDLE) && i_instr_valid;

`ifdef TIS_EXEC_ANY_EN
    assign w_in_port_src = (w_in_src == SRC_UP) || (w_in_src == SRC_RIGHT) ||
                           (w_in_src == SRC_DOWN) || (w_in_src == SRC_LEFT) ||
                           (w_in_src == SRC_ANY);
`else
    assign w_in_port_src = (w_in_src == SRC_UP) || (w_in_src == SRC_RIGHT) ||
                           (w_in_src == SRC_DOWN) || (w_in_src == SRC_LEFT);
`endif

    // Register-sourced operands are captured at accept; ports fill in during FETCH.
    always_comb begin
        w_in_operand = '0;
        case (w_in_src)
            SRC_IMM: w_in_operand = word_t'(i_imm);
            SRC_ACC: w_in_operand = word_t'(i_acc);
            default: w_in_operand = '0;
        endcase
    end

    always_comb begin
        w_rd_idx  = 2'(r_src - SRC_UP);
        w_rd_fire = i_rd_valid[w_rd_idx];
`ifdef TIS_EXEC_ANY_EN
        if (r_src == SRC_ANY) begin
            w_rd_fire = |i_rd_valid;
            w_rd_idx  = '0;
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (i_rd_valid[i]) begin
                    w_rd_idx = 2'(i);
                end
            end
        end
`endif
    end

    assign w_rd_word = word_t'(i_rd_data[w_rd_idx*WORD_W +: WORD_W]);
    assign w_wr_idx  = 2'(r_dst - DST_UP);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_op      <= OP_NOP;
            r_src     <= SRC_IMM;
            r_dst     <= DST_ACC;
            r_operand <= '0;
        end else if (w_accept) begin
            r_op      <= w_in_op;
            r_src     <= w_in_src;
            r_dst     <= w_in_dst;
            r_operand <= w_in_operand;
        end else if ((r_state == ST_FETCH) && w_rd_fire) begin
            r_operand <= w_rd_word;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_instr_ready = 1'b0;
        o_rf_write    = 1'b0;
        o_rf_swap     = 1'b0;
        o_rf_save     = 1'b0;
        o_rd_ready    = '0;
        o_wr_valid    = '0;
        o_wr_data     = '0;
        case (r_state)
            ST_IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    if (op_reads_src(w_in_op) && w_in_port_src) begin
                        w_state_nxt = ST_FETCH;
                    end else if ((w_in_op == OP_MOV) && dst_is_port(w_in_dst)) begin
                        w_state_nxt = ST_PUSH;
                    end else begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_FETCH: begin
                if (w_rd_fire) begin
                    o_rd_ready[w_rd_idx] = 1'b1;
                    w_state_nxt = ((r_op == OP_MOV) && dst_is_port(r_dst)) ? ST_PUSH : ST_COMMIT;
                end
            end
            ST_PUSH: begin
                o_wr_valid[w_wr_idx] = 1'b1;
                o_wr_data = r_operand;
                if (i_wr_ready[w_wr_idx]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                case (r_op)
                    OP_MOV:  o_rf_write = (r_dst == DST_ACC);
                    OP_ADD:  o_rf_write = 1'b1;
                    OP_SUB:  o_rf_write = 1'b1;
                    OP_NEG:  o_rf_write = 1'b1;
                    OP_SWP:  o_rf_swap  = 1'b1;
                    OP_SAV:  o_rf_save  = 1'b1;
                    default: ;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_alu_op = ALU_PASS;
        case (r_op)
            OP_ADD:  w_alu_op = ALU_ADD;
            OP_SUB:  w_alu_op = ALU_SUB;
            OP_NEG:  w_alu_op = ALU_NEG;
            default: w_alu_op = ALU_PASS;
        endcase
    end

    tis_sat_addsub #(
        .W   (WORD_W),
        .SAT (SAT_MAX)
    ) u_sat (
        .i_a  (i_acc),
        .i_b  (r_operand),
        .i_op (w_alu_op),
        .o_y  (w_alu_y)
    );

    assign o_rf_write_data = o_rf_write ? w_alu_y : '0;
    assign o_busy          = (r_state != ST_IDLE);

endmodule
